// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC selection with four branch
// conditions and a circular return-address stack.
module pc_sequencer #(
  parameter int              PC_W        = 32,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [PC_W-1:0] PC_INC      = PC_W'(1)
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  input  logic            in_valid,
  input  logic            in_stall,
  input  logic            in_ctrl_branch,
  input  logic [1:0]      in_ctrl_btype,
  input  logic            in_ctrl_jump,
  input  logic            in_ctrl_call,
  input  logic            in_ctrl_ret,
  input  logic            in_ctrl_neg,
  input  logic            in_ctrl_zero,
  input  logic [PC_W-1:0] in_target,
  output logic [PC_W-1:0] out_pc,
  output logic            out_taken,
  output logic            out_flush,
  output logic            out_stack_empty,
  output logic            out_stack_full,
  output logic            out_err
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] stack [STACK_DEPTH];
  logic [AW-1:0]   ptr;
  logic [CW-1:0]   count;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] top;
  logic            cond;
  logic            br_taken;
  logic            accept;

  assign seq_pc = out_pc + PC_INC;
  assign top    = stack[ptr - AW'(1)];
  assign accept = in_valid && !in_stall;

  always_comb begin
    cond = 1'b0;
    unique case (in_ctrl_btype)
      2'd0: cond = in_ctrl_zero;
      2'd1: cond = in_ctrl_neg;
      2'd2: cond = !in_ctrl_zero;
      2'd3: cond = !in_ctrl_neg;
    endcase
  end

  assign br_taken  = in_ctrl_branch && cond;
  assign out_taken = in_valid && (in_ctrl_ret || in_ctrl_call
                     || in_ctrl_jump || br_taken);

  assign out_stack_empty = (count == '0);
  assign out_stack_full  = (count == CW'(STACK_DEPTH));

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_pc    <= RESET_PC;
      ptr       <= '0;
      count     <= '0;
      out_flush <= 1'b0;
      out_err   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      out_flush <= accept && out_taken;
      if (accept) begin
        if (in_ctrl_ret) begin
          if (!out_stack_empty) begin
            out_pc <= top;
            ptr    <= ptr - AW'(1);
            count  <= count - CW'(1);
          end else begin
            out_pc  <= seq_pc;
            out_err <= 1'b1;
          end
        end else if (in_ctrl_call) begin
          // A full stack drops its oldest entry: the pointer wraps onto it.
          stack[ptr] <= seq_pc;
          ptr        <= ptr + AW'(1);
          out_pc     <= in_target;
          if (out_stack_full) out_err <= 1'b1;
          else count <= count + CW'(1);
        end else if (in_ctrl_jump || br_taken) begin
          out_pc <= in_target;
        end else begin
          out_pc <= seq_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequencing, branches, stack
// nesting, overflow/underflow, priority, stall and async reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [1:0]  btype = 2'd0;
  logic        jump = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        neg = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] pc;
  logic        taken, flush, empty, full, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(valid),
    .in_stall(stall), .in_ctrl_branch(branch),
    .in_ctrl_btype(btype), .in_ctrl_jump(jump),
    .in_ctrl_call(call), .in_ctrl_ret(ret),
    .in_ctrl_neg(neg), .in_ctrl_zero(zero),
    .in_target(target), .out_pc(pc), .out_taken(taken),
    .out_flush(flush), .out_stack_empty(empty),
    .out_stack_full(full), .out_err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    valid = 0; stall = 0; branch = 0; btype = 0; jump = 0;
    call = 0; ret = 0; neg = 0; zero = 0; target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_jump(input logic [31:0] t);
    valid = 1; jump = 1; target = t;
    tick();
  endtask

  task automatic do_call(input logic [31:0] t);
    valid = 1; call = 1; target = t;
    tick();
  endtask

  task automatic do_ret();
    valid = 1; ret = 1;
    tick();
  endtask

  // Per btype: flags that make the branch taken / not taken.
  logic tk_z [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic tk_n [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic nt_z [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic nt_n [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    idle();
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    for (int i = 1; i <= 3; i++) begin
      valid = 1;
      tick();
      chk($sformatf("seq_pc%0d", i), pc, 32'(i));
      chk($sformatf("seq_flush%0d", i), 32'(flush), 32'd0);
      chk($sformatf("seq_empty%0d", i), 32'(empty), 32'd1);
    end

    for (int b = 0; b < 4; b++) begin
      do_jump(32'd10);
      chk($sformatf("jmp_flush_b%0d", b), 32'(flush), 32'd1);
      valid = 1; branch = 1; btype = 2'(b); target = 32'h40;
      zero = tk_z[b]; neg = tk_n[b];
      #1;
      chk($sformatf("br_taken_b%0d", b), 32'(taken), 32'd1);
      tick();
      chk($sformatf("br_pc_b%0d", b), pc, 32'h40);
      chk($sformatf("br_flush_b%0d", b), 32'(flush), 32'd1);
      tick();
      chk($sformatf("br_flush_off_b%0d", b), 32'(flush), 32'd0);
      do_jump(32'd10);
      valid = 1; branch = 1; btype = 2'(b); target = 32'h40;
      zero = nt_z[b]; neg = nt_n[b];
      #1;
      chk($sformatf("nt_taken_b%0d", b), 32'(taken), 32'd0);
      tick();
      chk($sformatf("nt_pc_b%0d", b), pc, 32'd11);
      chk($sformatf("nt_flush_b%0d", b), 32'(flush), 32'd0);
    end

    do_jump(32'h10);
    do_call(32'h100);
    chk("nest_c1", pc, 32'h100);
    chk("nest_c1_empty", 32'(empty), 32'd0);
    do_call(32'h200);
    chk("nest_c2", pc, 32'h200);
    do_ret();
    chk("nest_r1", pc, 32'h101);
    chk("nest_r1_flush", 32'(flush), 32'd1);
    do_ret();
    chk("nest_r2", pc, 32'h11);
    chk("nest_empty", 32'(empty), 32'd1);
    chk("nest_err", 32'(err), 32'd0);

    do_call(32'h20);
    do_call(32'h30);
    do_call(32'h40);
    chk("ovf_full3", 32'(full), 32'd0);
    do_call(32'h50);
    chk("ovf_full4", 32'(full), 32'd1);
    chk("ovf_err4", 32'(err), 32'd0);
    do_call(32'h60);
    chk("ovf_pc5", pc, 32'h60);
    chk("ovf_full5", 32'(full), 32'd1);
    chk("ovf_err5", 32'(err), 32'd1);
    do_ret();
    chk("ovf_r1", pc, 32'h51);
    do_ret();
    chk("ovf_r2", pc, 32'h41);
    do_ret();
    chk("ovf_r3", pc, 32'h31);
    do_ret();
    chk("ovf_r4", pc, 32'h21);
    chk("ovf_r4_empty", 32'(empty), 32'd1);
    do_ret();
    chk("udf_r5", pc, 32'h22);
    chk("udf_err", 32'(err), 32'd1);

    do_jump(32'h54);
    do_call(32'h70);
    valid = 1; ret = 1; call = 1; jump = 1; target = 32'h99;
    tick();
    chk("prio_pc", pc, 32'h55);
    chk("prio_empty", 32'(empty), 32'd1);
    chk("prio_flush", 32'(flush), 32'd1);

    do_jump(32'hFFFF_FFFF);
    valid = 1;
    tick();
    chk("wrap_pc", pc, 32'h0);

    do_jump(32'h55);
    valid = 1; stall = 1; jump = 1; target = 32'h80;
    #1;
    chk("stall_taken", 32'(taken), 32'd1);
    tick();
    chk("stall_pc", pc, 32'h55);
    chk("stall_flush", 32'(flush), 32'd0);
    do_call(32'h90);
    chk("pre_rst_flush", 32'(flush), 32'd1);
    chk("pre_rst_empty", 32'(empty), 32'd0);
    valid = 1; stall = 1; jump = 1; target = 32'h80;
    #1;
    rst_n = 0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_flush", 32'(flush), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    do_ret();
    chk("post_rst_udf_pc", pc, 32'h1);
    chk("post_rst_udf_err", 32'(err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
